// File: rtl/mole_round_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mole_round_ctrl_if                                           |
// | Description : Control/position bundle between the top level, the RNG, the  |
// |               round scheduler and the LED activation block.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mole_round_ctrl_if;
  logic       start;
  logic       abort;
  logic [3:0] rng_a;
  logic [3:0] rng_b;
  logic [9:0] hit_LEDs;
  logic       LED_toggle;
  logic [3:0] rng_led;
  logic [3:0] rng_led2;
  logic [9:0] active_mask;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] round_idx;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, rng_a, rng_b, hit_LEDs,
    input  LED_toggle, rng_led, rng_led2, active_mask,
    input  score, misses, round_idx, busy, done
  );

  modport slave (
    input  start, abort, rng_a, rng_b, hit_LEDs,
    output LED_toggle, rng_led, rng_led2, active_mask,
    output score, misses, round_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mole_round_ctrl                                              |
// | Description : Whack-a-mole round scheduler: timed mole windows and gaps,   |
// |               distinct clamped positions, hit scoring and miss counting.   |
// |               Optional macro EARLY_ADVANCE_EN ends a window once all moles |
// |               have been hit.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mole_round_ctrl #(
  parameter int ROUND_TICKS = 50_000_000,
  parameter int GAP_TICKS   = 12_500_000,
  parameter int NUM_ROUNDS  = 20
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mole_round_ctrl_if.slave  bus
);

  localparam int c_MAX_TICKS = (ROUND_TICKS > GAP_TICKS) ? ROUND_TICKS : GAP_TICKS;
  localparam int c_TW        = $clog2(c_MAX_TICKS);

  localparam logic [c_TW-1:0] c_ROUND_LOAD = c_TW'(ROUND_TICKS - 1);
  localparam logic [c_TW-1:0] c_GAP_LOAD   = c_TW'(GAP_TICKS - 1);
  localparam logic [c_TW-1:0] c_ONE        = c_TW'(1);
  localparam logic [7:0]      c_LAST_ROUND = 8'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t          r_state;
  logic [c_TW-1:0] r_timer;
  logic            r_toggle;
  logic [3:0]      r_led;
  logic [3:0]      r_led2;
  logic [9:0]      r_mask;
  logic [7:0]      r_score;
  logic [7:0]      r_misses;
  logic [7:0]      r_round;
  logic            r_busy;
  logic            r_done;

  // Clamp raw RNG values to 0-9 and force B off A so both moles are distinct.
  logic [3:0] w_pa;
  logic [3:0] w_pb_raw;
  logic [3:0] w_pb;
  logic [9:0] w_load_mask;
  assign w_pa        = (bus.rng_a >= 4'd10) ? (bus.rng_a - 4'd10) : bus.rng_a;
  assign w_pb_raw    = (bus.rng_b >= 4'd10) ? (bus.rng_b - 4'd10) : bus.rng_b;
  assign w_pb        = (w_pb_raw != w_pa) ? w_pb_raw :
                       (w_pa == 4'd9)     ? 4'd0     : (w_pa + 4'd1);
  assign w_load_mask = (10'd1 << w_pa) | (10'd1 << w_pb);

  logic [9:0] w_mask_next;
  logic [7:0] w_score_next;
  logic [7:0] w_misses_next;
  logic [7:0] w_round_next;
  logic       w_timeout;
  logic       w_window_end;
  assign w_mask_next   = r_mask & ~bus.hit_LEDs;
  assign w_score_next  = sat_add(r_score, popcount10(bus.hit_LEDs & r_mask));
  assign w_misses_next = sat_add(r_misses, popcount10(w_mask_next));
  assign w_round_next  = r_round + 8'd1;
  assign w_timeout     = (r_timer == '0);
`ifdef EARLY_ADVANCE_EN
  assign w_window_end  = w_timeout || (w_mask_next == 10'd0);
`else
  assign w_window_end  = w_timeout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_toggle <= 1'b0;
      r_led    <= 4'd0;
      r_led2   <= 4'd0;
      r_mask   <= 10'd0;
      r_score  <= 8'd0;
      r_misses <= 8'd0;
      r_round  <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_toggle <= 1'b0;
      if (bus.abort) begin
        // Counters are held so the aborted game can still be read out.
        r_state <= S_IDLE;
        r_mask  <= 10'd0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              r_score  <= 8'd0;
              r_misses <= 8'd0;
              r_round  <= 8'd0;
              r_led    <= w_pa;
              r_led2   <= w_pb;
              r_mask   <= w_load_mask;
              r_toggle <= 1'b1;
              r_timer  <= c_ROUND_LOAD;
              r_state  <= S_ACTIVE;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
            end
          end
          S_ACTIVE: begin
            r_score <= w_score_next;
            if (w_window_end) begin
              r_misses <= w_misses_next;
              r_mask   <= 10'd0;
              r_round  <= w_round_next;
              if (w_round_next == c_LAST_ROUND) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GAP;
                r_timer <= c_GAP_LOAD;
              end
            end else begin
              r_mask  <= w_mask_next;
              r_timer <= r_timer - c_ONE;
            end
          end
          S_GAP: begin
            if (w_timeout) begin
              r_led    <= w_pa;
              r_led2   <= w_pb;
              r_mask   <= w_load_mask;
              r_toggle <= 1'b1;
              r_timer  <= c_ROUND_LOAD;
              r_state  <= S_ACTIVE;
            end else begin
              r_timer <= r_timer - c_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.LED_toggle  = r_toggle;
  assign bus.rng_led     = r_led;
  assign bus.rng_led2    = r_led2;
  assign bus.active_mask = r_mask;
  assign bus.score       = r_score;
  assign bus.misses      = r_misses;
  assign bus.round_idx   = r_round;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
Game-round scheduler for the whack-a-mole LED datapath. It sequences a fixed number of rounds and emits the one-cycle LED_toggle pulse plus two distinct, pre-clamped mole positions to the LED activation block. It tracks which moles are live, then scores hits from the one-hot hit vector and counts timed-out moles as misses. It sits between the top-level start/abort controls, the RNG and the LED activation block.

Parameters:
ROUND_TICKS, 50_000_000, clk cycles a mole window stays open (>=2)
GAP_TICKS, 12_500_000, clk cycles of dark gap between windows (>=1)
NUM_ROUNDS, 20, rounds per game (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  level; sampled in IDLE/DONE to begin a game
abort  in  1  synchronous return to IDLE; priority over all except rst
rng_a  in  4  raw RNG value, any 0-15
rng_b  in  4  raw RNG value, any 0-15
hit_LEDs  in  10  one-hot/multi-hot hit vector from mole detector
LED_toggle  out  1  registered one-cycle pulse, first cycle of each window
rng_led  out  4  mole position A, 0-9, held stable between pulses
rng_led2  out  4  mole position B, 0-9, always != rng_led
active_mask  out  10  moles still live this window
score  out  8  total hits this game, saturates at 255
misses  out  8  total unhit moles at window timeout, saturates at 255
round_idx  out  8  completed rounds this game
busy  out  1  high in ACTIVE or GAP
done  out  1  high in DONE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0.
- States: IDLE, ACTIVE, GAP, DONE. All outputs registered.
- IDLE/DONE, start=1: clear score, misses and round_idx. Load positions. Pulse LED_toggle. Load timer=ROUND_TICKS-1. Go to ACTIVE.
- Position load: pa=rng_a mod 10. pb=rng_b mod 10; if pb==pa then pb=(pa+1) mod 10. rng_led<=pa, rng_led2<=pb, active_mask<=(1<<pa)|(1<<pb).
- LED_toggle is high only in the first ACTIVE cycle of each window. Positions are valid in that same cycle.
- ACTIVE, every cycle including the first:
  - h=hit_LEDs & active_mask
  - score+=popcount(h), 0..2, saturating
  - active_mask&=~hit_LEDs
  - Hits on non-live LEDs are ignored.
- ACTIVE, timer==0 (window end):
  - Apply that cycle's hits first.
  - misses+=popcount(remaining mask), saturating.
  - active_mask<=0; round_idx+=1.
  - If the new round_idx==NUM_ROUNDS, go to DONE. Otherwise go to GAP with timer=GAP_TICKS-1.
- ACTIVE otherwise: timer-=1.
- GAP: timer-=1. At timer==0: load positions, pulse LED_toggle, timer=ROUND_TICKS-1, go to ACTIVE.
- DONE: score, misses and round_idx are held until the next start.
- Window length is exactly ROUND_TICKS cycles. Gap length is exactly GAP_TICKS cycles. Period is ROUND_TICKS+GAP_TICKS.
- abort=1: go to IDLE; active_mask<=0; LED_toggle<=0; score, misses and round_idx are held.
- Simultaneous abort and window end: abort wins; no miss accounting that cycle.
- start is ignored in ACTIVE and GAP.
- Timer width: $clog2 of max(ROUND_TICKS, GAP_TICKS).

Optional Feature:
EARLY_ADVANCE_EN
- Defined: in ACTIVE, if a cycle's hits clear active_mask to 0 before timeout, the window ends that cycle. Normal window-end handling applies with 0 misses.
- Undefined: the window always runs the full ROUND_TICKS, even when all moles are already hit.

Test Plan:
Common parameters: ROUND_TICKS=8, GAP_TICKS=2, NUM_ROUNDS=3.
1. Reset, then start=1 with rng_a=3, rng_b=12 -> next cycle LED_toggle=1, rng_led=3, rng_led2=2, active_mask=0x00C, busy=1.
2. rng_a=7, rng_b=7 -> rng_led=7, rng_led2=8. rng_a=9, rng_b=9 -> rng_led=9, rng_led2=0, active_mask=0x201.
3. Window with mask 0x00C; hit_LEDs=0x004 on cycle 3 and 0x3F0 on cycle 5 -> score=1, active_mask=0x008. At timeout: misses=1, active_mask=0. Next LED_toggle arrives exactly 10 cycles after the previous one.
4. No hits for 3 rounds -> misses=6, round_idx=3, done=1, busy=0. A further start clears the counters and pulses LED_toggle.
5. abort during GAP of round 2 -> IDLE, active_mask=0, round_idx=1 held, no LED_toggle. Also: abort and timeout in the same cycle -> misses unchanged.
6. With EARLY_ADVANCE_EN, hit_LEDs=0x00C on cycle 2 -> score=2, misses=0, GAP entered the next cycle. Without EARLY_ADVANCE_EN, GAP is entered after 8 ACTIVE cycles.
